// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered valid/ready 64-bit ALU execute stage with Y86 condition codes
// Optional accepted-operation counter on op_count when ALU_OPCOUNT_EN is defined.
module alu_exec_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [2:0]       cc
`ifdef ALU_OPCOUNT_EN
  ,
  output logic [31:0]      op_count
`endif
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             accept;
  logic             consume;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Carry-out is discarded; OF is signed overflow of the truncated result.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = A + B;
        ovf    = (A[MSB] == B[MSB]) && (result[MSB] != A[MSB]);
      end
      OP_SUB: begin
        result = A - B;
        ovf    = (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]);
      end
      OP_AND: result = A & B;
      OP_XOR: result = A ^ B;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Out       <= '0;
      cc        <= 3'b100;
    end else begin
      if (accept) begin
        Out       <= result;
        out_valid <= 1'b1;
        if (set_cc) begin
          cc <= {(result == '0), result[MSB], ovf};
        end
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept && (op_count != 32'hFFFF_FFFF)) begin
      op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed and scoreboarded checks for alu_exec_stage
// Checks op_count only when ALU_OPCOUNT_EN is defined.
module tb_alu_exec_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic [2:0]   cc;
`ifdef ALU_OPCOUNT_EN
  logic [31:0]  op_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .cc        (cc)
`ifdef ALU_OPCOUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [2:0] model_cc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] r);
    logic zf, sf, of;
    zf = (r == 0);
    sf = ($signed(r) < 0);
    of = 1'b0;
    if (o == 2'd0)
      of = (($signed(a) >= 0) && ($signed(b) >= 0) && ($signed(r) < 0)) ||
           (($signed(a) < 0) && ($signed(b) < 0) && ($signed(r) >= 0));
    else if (o == 2'd1)
      of = (($signed(a) >= 0) && ($signed(b) < 0) && ($signed(r) < 0)) ||
           (($signed(a) < 0) && ($signed(b) >= 0) && ($signed(r) >= 0));
    return {zf, sf, of};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = 2'd0; A = '0; B = '0; set_cc = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (Out !== 64'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", Out); end
    checks++;
    if (cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", cc); end
`ifdef ALU_OPCOUNT_EN
    checks++;
    if (op_count !== 32'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1; in_valid = 1'b1; op = 2'd0; set_cc = 1'b1;
    A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'h1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    checks++;
    if (Out !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_out got=%h exp=8000000000000000", Out); end
    checks++;
    if (cc !== 3'b011) begin failures++; $display("FAIL add_cc got=%b exp=011", cc); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub_and();
    out_ready = 1'b1; in_valid = 1'b1; op = 2'd1; set_cc = 1'b1; A = 64'd5; B = 64'd5;
    tick();
    checks++;
    if (Out !== 64'h0) begin failures++; $display("FAIL sub_out got=%h exp=0", Out); end
    checks++;
    if (cc !== 3'b100) begin failures++; $display("FAIL sub_cc got=%b exp=100", cc); end
    op = 2'd2; set_cc = 1'b0; A = 64'd0; B = 64'd3;
    tick();
    checks++;
    if (Out !== 64'h0) begin failures++; $display("FAIL and_out got=%h exp=0", Out); end
    checks++;
    if (cc !== 3'b100) begin failures++; $display("FAIL and_cc_hold got=%b exp=100", cc); end
    op = 2'd3; set_cc = 1'b0; A = 64'd1; B = 64'd2;
    tick();
    in_valid = 1'b0;
    checks++;
    if (Out !== 64'h3) begin failures++; $display("FAIL xor_nocc_out got=%h exp=3", Out); end
    checks++;
    if (cc !== 3'b100) begin failures++; $display("FAIL xor_nocc_cc got=%b exp=100", cc); end
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd3; set_cc = 1'b1; A = 64'hF0; B = 64'hFF;
    tick();
    op = 2'd0; A = '1; B = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      checks++;
      if (Out !== 64'h0F || out_valid !== 1'b1 || cc !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h/%b/%b exp=0f/1/000", i, Out, out_valid, cc);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (Out !== 64'hFFFF_FFFF_FFFF_FFFE || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_out got=%h/%b exp=fffffffffffffffe/1", Out, out_valid);
    end
    checks++;
    if (cc !== 3'b010) begin failures++; $display("FAIL same_cycle_cc got=%b exp=010", cc); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd3; set_cc = 1'b1; A = 64'd5; B = 64'd3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Out !== 64'h6) begin
      failures++;
      $display("FAIL pre_rst_stall got=%b/%h exp=1/6", out_valid, Out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || Out !== 64'h0 || cc !== 3'b100) begin
      failures++;
      $display("FAIL rst_stall got=%b/%h/%b exp=0/0/100", out_valid, Out, cc);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_r;
    logic [2:0]   exp_cc;
    int           ai, bi, cyc, accepted;
    bit           feed_done, adv;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_cc = 3'b100;
    ai = 1; bi = 1; cyc = 0; accepted = 0; feed_done = 0;
    in_valid = 1'b1;
    op = 2'($urandom_range(0, 3));
    set_cc = 1'($urandom_range(0, 1));
    A = 64'(ai) * 64'h0123_4567_89AB_CDEF;
    B = 64'(bi) * 64'hFEDC_BA98_7654_3211;
    while ((!feed_done || q.size() > 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra cyc=%0d got=%h exp=none", cyc, Out);
        end else begin
          exp_r = q.pop_front();
          if (Out !== exp_r) begin
            failures++;
            $display("FAIL stream_out cyc=%0d got=%h exp=%h", cyc, Out, exp_r);
          end
        end
      end
      adv = in_valid && in_ready;
      if (adv) begin
        exp_r = model_res(op, A, B);
        q.push_back(exp_r);
        if (set_cc) exp_cc = model_cc(op, A, B, exp_r);
        accepted++;
      end
      tick();
      cyc++;
      checks++;
      if (cc !== exp_cc) begin failures++; $display("FAIL stream_cc cyc=%0d got=%b exp=%b", cyc, cc, exp_cc); end
      if (adv) begin
        if (bi == 64) begin bi = 1; ai++; end else bi++;
        if (ai > 64) begin
          feed_done = 1;
          in_valid = 1'b0;
        end else begin
          op = 2'($urandom_range(0, 3));
          set_cc = 1'($urandom_range(0, 1));
          A = 64'(ai) * 64'h0123_4567_89AB_CDEF;
          B = 64'(bi) * 64'hFEDC_BA98_7654_3211;
        end
      end
    end
    checks++;
    if (cyc >= 20000) begin failures++; $display("FAIL stream_timeout got=%0d exp<20000", cyc); end
    checks++;
    if (accepted != 4096) begin failures++; $display("FAIL stream_accepted got=%0d exp=4096", accepted); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
`ifdef ALU_OPCOUNT_EN
    checks++;
    if (op_count !== 32'd4096) begin failures++; $display("FAIL stream_op_count got=%0d exp=4096", op_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_and();
    test_back_pressure();
    test_reset_mid_stall();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
